y_serializer: RTL
=================

Name: y_serializer

Overview:
- Parallel-in, serial-out output buffer for the convolution datapath.
- Captures a full vector of convolution results (y words) in one cycle.
- Streams the words out one per handshake on a valid/ready output interface, index 0 first.
- Sits between the MAC array and the module's y output port.

Parameters:
WIDTH, 16, bit width of each signed data word
SIZE, 64, maximum number of words held per frame
LOGSIZE, 6, log2(SIZE); counters are LOGSIZE+1 bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH x SIZE (signed, unpacked array)  parallel result vector; element i is word i
load_len  input  LOGSIZE+1  number of valid words in data_in for this frame
s_valid_in  input  1  producer asserts when data_in/load_len are valid
s_ready_in  output  1  block can accept a new frame
data_out  output  WIDTH (signed)  current serial word
m_valid_out  output  1  data_out valid
m_ready_out  input  1  consumer accepts data_out this cycle

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates occur only on the rising edge of clk.
- Reset values: state=IDLE, s_ready_in=1, m_valid_out=0, data_out=0, remaining=0, storage contents don't-care.
- States: IDLE and SEND.
  - s_ready_in = (state==IDLE), decoded from the state register.
  - m_valid_out = (state==SEND).
- IDLE behaviour:
  - On s_valid_in & s_ready_in with load_len!=0: capture all SIZE words of data_in, set remaining=min(load_len, SIZE), go to SEND.
  - First word appears on data_out in the cycle after the load edge (latency 1).
  - load_len==0: handshake completes, nothing is captured, state stays IDLE.
  - load_len>SIZE: clamped to SIZE.
- SEND behaviour:
  - data_out = stored word 0 of the remaining queue.
  - Transfer occurs when m_valid_out & m_ready_out.
  - On each transfer, storage shifts down by one (word i+1 -> word i, top word filled with 0) and remaining decrements.
  - Transfer with remaining==1 returns the block to IDLE: m_valid_out=0 and s_ready_in=1 in the next cycle.
  - There is always exactly one bubble cycle between frames; no back-to-back frame overlap.
- Stall: while m_valid_out=1 & m_ready_out=0, data_out and m_valid_out must hold stable (AXI-stream rule).
- s_valid_in during SEND is ignored; s_ready_in=0, so no capture occurs.
- Frame ordering: words emerge in index order 0..load_len-1. The unused upper words of the frame are never emitted.
- Throughput: 1 word/cycle when m_ready_out is held high. A frame of length L occupies L+1 cycles from load edge to next s_ready_in.
- Reset mid-SEND: remaining words are discarded; the block returns to IDLE with m_valid_out=0 on the next cycle.
- Reset has priority over simultaneous load or transfer.
- No arithmetic on data; words pass through bit-exact, signed, WIDTH bits.

Decomposition:
- conv_pkg holds:
  - default WIDTH/SIZE/LOGSIZE constants
  - state enum typedef ser_state_t {IDLE, SEND}
  - word typedef (logic signed [WIDTH-1:0])
- One sub-module: y_shift_reg.
  - Function: parallel load, shift-down-by-one storage with an enable; the mirror of the serial-write/parallel-read x store.
  - Ports: clk, load, shift, data_in[SIZE], data_out word 0.
  - The FSM and remaining counter live in y_serializer.

Test Plan:
- Reset: hold reset 2 cycles -> s_ready_in=1, m_valid_out=0, data_out=0. Then load words {5,-3,7} with load_len=3 and m_ready_out=1 -> data_out 5,-3,7 on three consecutive cycles, then m_valid_out=0 for one cycle, then s_ready_in=1.
- Backpressure: load {100,200} with load_len=2; hold m_ready_out=0 for 4 cycles -> data_out stays 100 with m_valid_out=1. Then toggle m_ready_out 1,0,1 -> 200 emitted only on the second accepted beat.
- Boundaries:
  - load_len=0 -> no m_valid_out, s_ready_in stays 1.
  - load_len=SIZE (64) with ramp 0..63 -> 64 words in order.
  - load_len=70 -> clamped, exactly 64 words.
- Ignore during SEND: assert s_valid_in with new data {9,9} during SEND -> no capture, current frame completes unchanged, s_ready_in=0 throughout.
- Reset mid-frame: load 10 words, accept 4, assert reset -> next cycle m_valid_out=0, s_ready_in=1. A new frame {1} then outputs exactly 1.
- Signed extremes: words 0x8000 and 0x7FFF -> emitted bit-exact.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath output path.
// Provides the default word/frame geometry, the serializer state type,
// the signed data word type, and a frame-length clamp helper.
package conv_pkg;

  localparam int CONV_WIDTH   = 16;
  localparam int CONV_SIZE    = 64;
  localparam int CONV_LOGSIZE = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef logic signed [CONV_WIDTH-1:0] word_t;

  // A producer may request more words than the store holds; the excess is
  // simply not there to send, so the frame length saturates at the store size.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned size);
    return (len > size) ? size : len;
  endfunction

endpackage

// File: rtl/y_shift_reg.sv
// Parallel-load, shift-down-by-one word store.
// Ports:
//   clk      rising-edge clock
//   load     capture all SIZE words of data_in (has priority over shift)
//   shift    move word i+1 into word i, top word becomes 0
//   data_in  parallel word vector, element i is word i
//   data_out current word 0 of the store
// Contents are not reset; the owner qualifies data_out with its own state.
module y_shift_reg #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 64
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic                    shift,
  input  logic signed [WIDTH-1:0] data_in [SIZE],
  output logic signed [WIDTH-1:0] data_out
);

  logic signed [WIDTH-1:0] words_q [SIZE];
  logic signed [WIDTH-1:0] words_d [SIZE];

  always_comb begin
    words_d = words_q;
    if (load) begin
      words_d = data_in;
    end else if (shift) begin
      for (int i = 0; i < SIZE - 1; i++) begin
        words_d[i] = words_q[i+1];
      end
      words_d[SIZE-1] = '0;
    end
  end

  always_ff @(posedge clk) begin
    words_q <= words_d;
  end

  assign data_out = words_q[0];

endmodule

// File: rtl/y_serializer.sv
// Parallel-in, serial-out buffer between the MAC array and the y port.
// A whole result vector is captured in one handshake, then streamed out
// one word per valid/ready beat, index 0 first.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   data_in[SIZE]     parallel result vector (signed words)
//   load_len          number of valid words in this frame (clamped to SIZE)
//   s_valid_in        producer has a frame on data_in/load_len
//   s_ready_in        block is idle and can accept a frame
//   data_out          current serial word (0 when not valid)
//   m_valid_out       data_out is valid
//   m_ready_out       consumer takes data_out this cycle
module y_serializer
  import conv_pkg::*;
#(
  parameter int WIDTH   = CONV_WIDTH,
  parameter int SIZE    = CONV_SIZE,
  parameter int LOGSIZE = CONV_LOGSIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] data_in [SIZE],
  input  logic [LOGSIZE:0]        load_len,
  input  logic                    s_valid_in,
  output logic                    s_ready_in,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    m_valid_out,
  input  logic                    m_ready_out
);

  ser_state_t         state_q, state_d;
  logic [LOGSIZE:0]   remaining_q, remaining_d;
  logic               load;
  logic               xfer;
  logic signed [WIDTH-1:0] head_word;

  assign s_ready_in  = (state_q == IDLE);
  assign m_valid_out = (state_q == SEND);

  // A zero-length frame completes its handshake without capturing anything.
  assign load = s_valid_in && s_ready_in && (load_len != '0);
  assign xfer = m_valid_out && m_ready_out;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          remaining_d = (LOGSIZE+1)'(clamp_len(32'(load_len), SIZE));
          state_d     = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          remaining_d = remaining_q - (LOGSIZE+1)'(1);
          if (remaining_q == (LOGSIZE+1)'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  y_shift_reg #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_store (
    .clk      (clk),
    .load     (load),
    .shift    (xfer),
    .data_in  (data_in),
    .data_out (head_word)
  );

  // The store itself is never reset, so the output is forced to zero outside
  // SEND; this gives a defined data_out after reset and between frames.
  assign data_out = m_valid_out ? head_word : '0;

endmodule
